// File: rtl/block_fifo_pkg.sv
// Shared helpers for the width-converting FIFO: sizing functions and a parameter guard.
// Latency: n/a (elaboration-time only).
// Backpressure: n/a.
package block_fifo_pkg;

   // Ceiling log2 for elaboration-time sizing (clog2(1) = 0).
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int min_w(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int max_w(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Width of a count that must reach depth_n/ratio inclusive.
   function automatic int cnt_w(input int depth_n, input int ratio);
      return clog2(depth_n / ratio) + 1;
   endfunction

endpackage

// Elaboration-time guard: instantiates an $error when the parameter set is illegal.
`define BLOCK_FIFO_CHECK(cond) \
   if (!(cond)) begin : g_param_check \
      $error("block_width_fifo: illegal parameter combination"); \
   end

// File: rtl/block_width_fifo_sdp_ram.sv
// Simple dual-port RAM, one write port and one read port, rows of W bits.
// Latency: read data registered, valid the cycle after re.
// Backpressure: none; rdat holds its value while re is low.
// Ports: okClk/reset_n clock and async reset (read register only);
//        we/waddr/wdat write port; re/raddr/rdat registered read port.
module sdp_ram #(
   parameter int W    = 256,
   parameter int ROWS = 128,
   parameter int AW   = 7
) (
   input  logic          okClk,
   input  logic          reset_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdat,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdat
);

   logic [W-1:0] mem [ROWS];

   always_ff @(posedge okClk) begin
      if (we) mem[waddr] <= wdat;
   end

   always_ff @(posedge okClk or negedge reset_n) begin
      if (!reset_n)  rdat <= '0;
      else if (re)   rdat <= mem[raddr];
   end

endmodule

// File: rtl/block_width_fifo.sv
// Width-converting single-clock FIFO (IN_W -> OUT_W) with block-ready throttle and sticky errors.
// Latency: read data one cycle after an accepted rd_en; with FWFT_EN the head word falls through.
// Backpressure: writes while full are dropped (overflow), reads while empty ignored (underflow).
// Ports: okClk, reset_n (async active-low); din/wr_en write side; rd_en/dout/valid read side;
//        full, empty, wr_count, rd_count, in_block_ready, out_block_ready, overflow, underflow status.
// Build option: define FWFT_EN for first-word-fall-through; rd_en then acknowledges the shown word.
module block_width_fifo
   import block_fifo_pkg::*;
#(
   parameter int IN_W      = 32,
   parameter int OUT_W     = 256,
   parameter int DEPTH_N   = 1024,
   parameter int BLOCK_IN  = 128,
   parameter int BLOCK_OUT = 16,
   parameter int WCW       = cnt_w(DEPTH_N, IN_W / min_w(IN_W, OUT_W)),
   parameter int RCW       = cnt_w(DEPTH_N, OUT_W / min_w(IN_W, OUT_W))
) (
   input  logic             okClk,
   input  logic             reset_n,
   input  logic [IN_W-1:0]  din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [OUT_W-1:0] dout,
   output logic             valid,
   output logic             full,
   output logic             empty,
   output logic [WCW-1:0]   wr_count,
   output logic [RCW-1:0]   rd_count,
   output logic             in_block_ready,
   output logic             out_block_ready,
   output logic             overflow,
   output logic             underflow
);

   localparam int N     = min_w(IN_W, OUT_W);
   localparam int W     = max_w(IN_W, OUT_W);   // RAM row width
   localparam int RI    = IN_W / N;
   localparam int RO    = OUT_W / N;
   localparam int WSUBS = W / IN_W;             // input words per row
   localparam int SUBS  = W / OUT_W;            // output words per row
   localparam int ROWS  = DEPTH_N / (W / N);
   localparam int AW    = clog2(ROWS);
   localparam int FW    = clog2(DEPTH_N) + 1;
   localparam int SELW  = (SUBS > 1) ? clog2(SUBS) : 1;
   localparam int PCW   = (WSUBS > 1) ? clog2(WSUBS) : 1;

   `BLOCK_FIFO_CHECK((W % N == 0) && ((DEPTH_N & (DEPTH_N - 1)) == 0) && (ROWS >= 2)
                     && (BLOCK_IN <= DEPTH_N / RI) && (BLOCK_OUT <= DEPTH_N / RO))

   logic            wr_acc, rd_acc, issue;
   logic            row_we;
   logic [W-1:0]    row_wdat, ram_q;
   logic [AW-1:0]   wr_row_q, rd_row_q;
   logic [SELW-1:0] rd_sub_q, rd_sel_q;
   logic [FW-1:0]   fill_q, fill_nxt;
   logic            full_q, valid_q, ibr_q, obr_q, ovf_q, unf_q;
   logic [WCW-1:0]  wr_count_q;
   logic [RCW-1:0]  rd_count_q;

   assign wr_acc = wr_en && !full_q;

`ifdef FWFT_EN
   // Prefetch tracking: ufill counts units not yet pulled into the output register,
   // while fill (and therefore all status) still includes the presented word.
   logic [FW-1:0] ufill_q, ufill_nxt;
   assign rd_acc = rd_en && valid_q;
   assign issue  = (ufill_q >= FW'(RO)) && (!valid_q || rd_en);
   assign empty  = !valid_q;

   always_comb begin
      ufill_nxt = ufill_q;
      if (wr_acc) ufill_nxt = ufill_nxt + FW'(RI);
      if (issue)  ufill_nxt = ufill_nxt - FW'(RO);
   end

   always_ff @(posedge okClk or negedge reset_n) begin
      if (!reset_n) ufill_q <= '0;
      else          ufill_q <= ufill_nxt;
   end
`else
   logic empty_q;
   assign rd_acc = issue;
   assign issue  = rd_en && !empty_q;
   assign empty  = empty_q;
`endif

   always_comb begin
      fill_nxt = fill_q;
      if (wr_acc) fill_nxt = fill_nxt + FW'(RI);
      if (rd_acc) fill_nxt = fill_nxt - FW'(RO);
   end

   // Upsize: collect input words, first one lands in the MS slice of the row.
   if (WSUBS > 1) begin : g_pack
      logic [W-IN_W-1:0] pack_q;
      logic [PCW-1:0]    cnt_q;
      assign row_we   = wr_acc && (cnt_q == PCW'(WSUBS - 1));
      assign row_wdat = {pack_q, din};
      always_ff @(posedge okClk or negedge reset_n) begin
         if (!reset_n) begin
            pack_q <= '0;
            cnt_q  <= '0;
         end else if (wr_acc) begin
            pack_q <= (W-IN_W)'({pack_q, din});
            cnt_q  <= row_we ? '0 : cnt_q + 1'b1;
         end
      end
   end else begin : g_direct
      assign row_we   = wr_acc;
      assign row_wdat = din;
   end

   sdp_ram #(.W(W), .ROWS(ROWS), .AW(AW)) u_ram (
      .okClk   (okClk),
      .reset_n (reset_n),
      .we      (row_we),
      .waddr   (wr_row_q),
      .wdat    (row_wdat),
      .re      (issue),
      .raddr   (rd_row_q),
      .rdat    (ram_q)
   );

   // Downsize: slice 0 is the MS part of the row; rows are re-read per slice.
   assign dout = OUT_W'(ram_q >> ((SUBS - 1 - int'(rd_sel_q)) * OUT_W));

   always_ff @(posedge okClk or negedge reset_n) begin
      if (!reset_n) begin
         wr_row_q   <= '0;
         rd_row_q   <= '0;
         rd_sub_q   <= '0;
         rd_sel_q   <= '0;
         fill_q     <= '0;
         full_q     <= 1'b0;
`ifndef FWFT_EN
         empty_q    <= 1'b1;
`endif
         wr_count_q <= '0;
         rd_count_q <= '0;
         valid_q    <= 1'b0;
         ibr_q      <= 1'b0;
         obr_q      <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         if (row_we) wr_row_q <= (wr_row_q == AW'(ROWS - 1)) ? '0 : wr_row_q + 1'b1;
         if (issue) begin
            rd_sel_q <= rd_sub_q;
            if (rd_sub_q == SELW'(SUBS - 1)) begin
               rd_sub_q <= '0;
               rd_row_q <= (rd_row_q == AW'(ROWS - 1)) ? '0 : rd_row_q + 1'b1;
            end else begin
               rd_sub_q <= rd_sub_q + 1'b1;
            end
         end
`ifdef FWFT_EN
         valid_q    <= issue || (valid_q && !rd_en);
`else
         valid_q    <= issue;
         empty_q    <= fill_nxt < FW'(RO);
`endif
         fill_q     <= fill_nxt;
         full_q     <= fill_nxt > FW'(DEPTH_N - RI);
         wr_count_q <= WCW'(fill_nxt / FW'(RI));
         rd_count_q <= RCW'(fill_nxt / FW'(RO));
         // Block flags deliberately lag the counts by one more cycle.
         ibr_q      <= wr_count_q <= WCW'(DEPTH_N / RI - BLOCK_IN);
         obr_q      <= rd_count_q >= RCW'(BLOCK_OUT);
         if (wr_en && full_q) ovf_q <= 1'b1;
         if (rd_en && empty)  unf_q <= 1'b1;
      end
   end

   assign valid           = valid_q;
   assign full            = full_q;
   assign wr_count        = wr_count_q;
   assign rd_count        = rd_count_q;
   assign in_block_ready  = ibr_q;
   assign out_block_ready = obr_q;
   assign overflow        = ovf_q;
   assign underflow       = unf_q;

endmodule

// File: tb/tb_block_width_fifo.sv
// Bench for block_width_fifo: a 32->256 instance and a 64->32 instance on one clock.
// Latency: expected words queued at stimulus time, checked by a negedge monitor.
// Backpressure: monitor takes a word on valid (FWFT_EN: valid && rd_en).
module tb_block_width_fifo;

   logic okClk = 1'b0;
   logic reset_n = 1'b1;
   initial forever #5 okClk = ~okClk;

   // 32 -> 256 instance
   logic [31:0]  din0 = '0;
   logic         wr_en0 = 1'b0, rd_en0 = 1'b0;
   logic [255:0] dout0;
   logic         valid0, full0, empty0, ibr0, obr0, ovf0, unf0;
   logic [10:0]  wr_count0;
   logic [7:0]   rd_count0;

   // 64 -> 32 instance
   logic [63:0]  din1 = '0;
   logic         wr_en1 = 1'b0, rd_en1 = 1'b0;
   logic [31:0]  dout1;
   logic         valid1, full1, empty1, ibr1, obr1, ovf1, unf1;
   logic [9:0]   wr_count1;
   logic [10:0]  rd_count1;

   block_width_fifo u0 (
      .okClk(okClk), .reset_n(reset_n), .din(din0), .wr_en(wr_en0), .rd_en(rd_en0),
      .dout(dout0), .valid(valid0), .full(full0), .empty(empty0),
      .wr_count(wr_count0), .rd_count(rd_count0), .in_block_ready(ibr0),
      .out_block_ready(obr0), .overflow(ovf0), .underflow(unf0));

   block_width_fifo #(.IN_W(64), .OUT_W(32)) u1 (
      .okClk(okClk), .reset_n(reset_n), .din(din1), .wr_en(wr_en1), .rd_en(rd_en1),
      .dout(dout1), .valid(valid1), .full(full1), .empty(empty1),
      .wr_count(wr_count1), .rd_count(rd_count1), .in_block_ready(ibr1),
      .out_block_ready(obr1), .overflow(ovf1), .underflow(unf1));

   int checks = 0;
   int errors = 0;
   logic [255:0] q0 [$];
   logic [31:0]  q1 [$];
   logic [255:0] row1;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge okClk);
      #1;
   endtask

   // Eight consecutive 32-bit values, first one in the MS slice.
   function automatic logic [255:0] row_of(input logic [31:0] base);
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r = {r[223:0], base + 32'(i)};
      return r;
   endfunction

   task automatic read0(input int n);
      for (int i = 0; i < n; i++) begin
         rd_en0 = 1'b1;
         step();
      end
      rd_en0 = 1'b0;
   endtask

   // Monitor: one scoreboard pop per delivered word.
   logic take0, take1;
`ifdef FWFT_EN
   assign take0 = valid0 && rd_en0;
   assign take1 = valid1 && rd_en1;
`else
   assign take0 = valid0;
   assign take1 = valid1;
`endif

   always @(negedge okClk) begin
      if (take0) begin
         if (q0.size() == 0) chk("u0_unexpected_word", {255'd0, valid0}, 256'd0);
         else chk("u0_dout", dout0, q0.pop_front());
      end
      if (take1) begin
         if (q1.size() == 0) chk("u1_unexpected_word", {255'd0, valid1}, 256'd0);
         else chk("u1_dout", {224'd0, dout1}, {224'd0, q1.pop_front()});
      end
   end

   initial begin
      row1 = 256'h000fffff_000eeeee_000ddddd_000ccccc_000bbbbb_000aaaaa_00099999_00088888;

      // Reset state
      #2 reset_n = 1'b0;
      #6;
      chk("rst_dout", dout0, 256'd0);
      chk("rst_valid", valid0, 0);
      chk("rst_full", full0, 0);
      chk("rst_empty", empty0, 1);
      chk("rst_wr_count", wr_count0, 0);
      chk("rst_rd_count", rd_count0, 0);
      chk("rst_ibr", ibr0, 0);
      chk("rst_obr", obr0, 0);
      chk("rst_ovf", ovf0, 0);
      chk("rst_unf", unf0, 0);
      step();
      reset_n = 1'b1;
      step();
      chk("ibr_after_rst", ibr0, 1);
      chk("obr_after_rst", obr0, 0);

      // Downsize 64 -> 32: MS half read first
      wr_en1 = 1'b1; din1 = 64'hAAAA0000_BBBB1111;
      step();
      din1 = 64'h12345678_9ABCDEF0;
      step();
      wr_en1 = 1'b0;
      step();
      chk("u1_wr_count", wr_count1, 2);
      chk("u1_rd_count", rd_count1, 4);
      q1.push_back(32'hAAAA0000);
      q1.push_back(32'hBBBB1111);
      q1.push_back(32'h12345678);
      q1.push_back(32'h9ABCDEF0);
      for (int i = 0; i < 4; i++) begin
         rd_en1 = 1'b1;
         step();
      end
      rd_en1 = 1'b0;
      step();
      chk("u1_empty_after", empty1, 1);
      chk("u1_q_drained", q1.size(), 0);

      // Upsize 32 -> 256: eight words form one row
      for (int i = 0; i < 8; i++) begin
         wr_en0 = 1'b1;
         din0 = 32'h000fffff - 32'(i) * 32'h00011111;
         step();
      end
      wr_en0 = 1'b0;
      step();
      chk("t1_wr_count", wr_count0, 8);
      chk("t1_rd_count", rd_count0, 1);
      chk("t1_empty", empty0, 0);
`ifdef FWFT_EN
      chk("t1_fwft_valid", valid0, 1);
      chk("t1_fwft_dout", dout0, row1);
`else
      chk("t1_valid_idle", valid0, 0);
`endif
      q0.push_back(row1);
      read0(1);
`ifdef FWFT_EN
      chk("t1_valid_after_ack", valid0, 0);
`else
      chk("t1_valid_latency", valid0, 1);
`endif
      chk("t1_empty_after", empty0, 1);
      step();
      chk("t1_valid_pulse", valid0, 0);
      chk("t1_rd_count_after", rd_count0, 0);

      // Read while empty
      read0(1);
      chk("t4_valid", valid0, 0);
      chk("t4_underflow", unf0, 1);
      chk("t4_rd_count", rd_count0, 0);
      chk("t4_dout_held", dout0, row1);
      chk("t4_no_overflow", ovf0, 0);

      // Fill to capacity, then one extra write
      for (int k = 1; k <= 1025; k++) begin
         wr_en0 = 1'b1;
         din0 = (k == 1025) ? 32'hDEADBEEF : 32'(k);
         step();
         if (k == 897) begin
            chk("t3_wr_count_897", wr_count0, 897);
            chk("t3_ibr_still_high", ibr0, 1);
         end
         if (k == 898)  chk("t3_ibr_drop", ibr0, 0);
         if (k == 1023) chk("t3_not_full_1023", full0, 0);
         if (k == 1024) begin
            chk("t3_full", full0, 1);
            chk("t3_wr_count_1024", wr_count0, 1024);
            chk("t3_obr", obr0, 1);
            chk("t3_ovf_before", ovf0, 0);
         end
         if (k == 1025) begin
            chk("t3_overflow", ovf0, 1);
            chk("t3_wr_count_hold", wr_count0, 1024);
         end
      end
      wr_en0 = 1'b0;
      for (int j = 0; j < 128; j++) q0.push_back(row_of(32'(8 * j + 1)));
      read0(128);
      step();
      chk("t3_empty_after_drain", empty0, 1);
      chk("t3_rd_count_after_drain", rd_count0, 0);
      chk("t3_q_drained", q0.size(), 0);
      step();
      chk("t3_ibr_recovered", ibr0, 1);

      // Reset in the middle of a partial pack
      for (int i = 0; i < 5; i++) begin
         wr_en0 = 1'b1;
         din0 = 32'h5000 + 32'(i);
         step();
      end
      din0 = 32'h5005;
      reset_n = 1'b0;
      #1;
      chk("t5_wr_count", wr_count0, 0);
      chk("t5_rd_count", rd_count0, 0);
      chk("t5_empty", empty0, 1);
      chk("t5_ovf_cleared", ovf0, 0);
      chk("t5_unf_cleared", unf0, 0);
      chk("t5_valid", valid0, 0);
      chk("t5_dout", dout0, 256'd0);
      wr_en0 = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         wr_en0 = 1'b1;
         din0 = 32'h6000 + 32'(i);
         step();
      end
      wr_en0 = 1'b0;
      step();
      chk("t5_partial_wr_count", wr_count0, 3);
      chk("t5_partial_unreadable", rd_count0, 0);
      chk("t5_partial_empty", empty0, 1);
      for (int i = 3; i < 8; i++) begin
         wr_en0 = 1'b1;
         din0 = 32'h6000 + 32'(i);
         step();
      end
      wr_en0 = 1'b0;
      step();
      chk("t5_rd_count_one", rd_count0, 1);
      q0.push_back(row_of(32'h6000));
      read0(1);
      step();
      step();
      chk("end_q0_drained", q0.size(), 0);
      chk("end_q1_drained", q1.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
